// File: rtl/accel_pkg.sv
// ADXL345 register map, SPI command encodings, request record and FSM state types for the X-axis reader.
// Pure declarations: no logic, no latency, no flow control.
package accel_pkg;

  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;

  localparam logic [7:0] DATA_FORMAT_VAL = 8'h08;  // full resolution, 4-wire SPI
  localparam logic [7:0] POWER_CTL_VAL   = 8'h08;  // measure mode

  localparam logic [1:0] CMD_WRITE_SB    = 2'b00;
  localparam logic [1:0] CMD_READ_MB     = 2'b11;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_CFG_FMT,
    ST_CFG_PWR,
    ST_WAIT,
    ST_READ_X,
    ST_UPDATE
  } rd_state_e;

  typedef enum logic [2:0] {
    XS_IDLE,
    XS_SETUP,
    XS_LOW,
    XS_HIGH,
    XS_GAP
  } xfer_state_e;

  // tx_dat is sent MSB first; only the top nbytes bytes are shifted out.
  typedef struct packed {
    logic [1:0]  nbytes;
    logic [23:0] tx_dat;
  } xfer_req_t;

  function automatic logic [7:0] spi_cmd(input logic [1:0] rw_mb, input logic [5:0] addr);
    return {rw_mb, addr};
  endfunction

endpackage

// File: rtl/spi_xfer_engine.sv
// Mode-3 SPI frame generator: CS setup, nbytes*8 SCLK periods of 2*HALF clocks, CS hold, CS-high gap, then done.
// rx byte strobed HALF cycles after its last SCLK rise; start is only honoured while idle (no other backpressure).
module spi_xfer_engine
  import accel_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  xfer_req_t  req,
  output logic       busy,
  output logic       done,
  output logic       rx_vld,
  output logic [1:0] rx_idx,
  output logic [7:0] rx_dat,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int            CW       = $clog2(2 * HALF) + 1;
  localparam logic [CW-1:0] PH_LAST  = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * HALF - 1);

  xfer_state_e   state, state_nxt;
  logic [CW-1:0] ph_cnt;
  logic [4:0]    bit_cnt;
  logic [4:0]    nbits;
  logic [23:0]   tx_sh;
  logic [7:0]    rx_sh;
  logic          ld, fall, rise, last_bit, ph_end;

  assign busy     = (state != XS_IDLE);
  assign last_bit = (bit_cnt == nbits);
  assign ph_end   = (ph_cnt == PH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= XS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    fall      = 1'b0;
    rise      = 1'b0;
    case (state)
      XS_IDLE:  if (start) begin state_nxt = XS_SETUP; ld = 1'b1; end
      XS_SETUP: if (ph_end) begin state_nxt = XS_LOW; fall = 1'b1; end
      XS_LOW:   if (ph_end) begin state_nxt = XS_HIGH; rise = 1'b1; end
      XS_HIGH: begin
        if (ph_end) begin
          if (last_bit) state_nxt = XS_GAP;
          else begin
            state_nxt = XS_LOW;
            fall      = 1'b1;
          end
        end
      end
      XS_GAP:   if (ph_cnt == GAP_LAST) state_nxt = XS_IDLE;
      default:  state_nxt = XS_IDLE;
    endcase
  end

  // Pin levels are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_cnt   <= '0;
      bit_cnt  <= '0;
      nbits    <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b1;
      spi_mosi <= 1'b0;
      rx_vld   <= 1'b0;
      rx_idx   <= '0;
      rx_dat   <= '0;
      done     <= 1'b0;
    end else begin
      ph_cnt   <= (state_nxt != state || state == XS_IDLE) ? '0 : ph_cnt + 1'b1;
      spi_cs_n <= (state_nxt == XS_IDLE) || (state_nxt == XS_GAP);
      spi_sclk <= (state_nxt != XS_LOW);
      done     <= (state == XS_GAP) && (state_nxt == XS_IDLE);
      rx_vld   <= 1'b0;
      if (ld) begin
        tx_sh    <= req.tx_dat;
        spi_mosi <= req.tx_dat[23];
        nbits    <= {req.nbytes, 3'b000};
        bit_cnt  <= '0;
      end
      if (fall) begin
        spi_mosi <= tx_sh[23];
        tx_sh    <= {tx_sh[22:0], 1'b0};
      end
      if (rise) begin
        rx_sh   <= {rx_sh[6:0], spi_miso};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (state == XS_HIGH && ph_end && bit_cnt[2:0] == 3'd0) begin
        rx_vld <= 1'b1;
        rx_idx <= bit_cnt[4:3] - 2'd1;
        rx_dat <= rx_sh;
      end
      if (state_nxt == XS_GAP && state != XS_GAP) spi_mosi <= 1'b0;
    end
  end

endmodule

// File: rtl/accel_spi_reader.sv
// ADXL345 X-axis reader: waits for sensor power-up, writes DATA_FORMAT and POWER_CTL, then burst-reads X every SAMPLE_CYC.
// accel_x_valid follows the last X1 SCLK rise by HALF+2 cycles; no backpressure, each sample is a one-cycle strobe.
module accel_spi_reader
  import accel_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int SPI_HZ      = 2_000_000,
  parameter int STARTUP_CYC = 50_000,
  parameter int SAMPLE_CYC  = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        init_done,
  output logic [15:0] accel_x,
  output logic        accel_x_valid
);

  localparam int HALF = CLK_HZ / (2 * SPI_HZ);
  localparam int SW   = $clog2(STARTUP_CYC + 1);
  localparam int PW   = $clog2(SAMPLE_CYC + 1);

  rd_state_e   state, state_nxt;
  logic [SW-1:0] start_cnt;
  logic [PW-1:0] samp_cnt;
  logic          tick;
  logic          xfer_start, xfer_busy, xfer_done;
  logic          rx_vld;
  logic [1:0]    rx_idx;
  logic [7:0]    rx_dat, x0_q, x1_q;
  xfer_req_t     req;

  spi_xfer_engine #(.HALF(HALF)) u_xfer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (xfer_start),
    .req      (req),
    .busy     (xfer_busy),
    .done     (xfer_done),
    .rx_vld   (rx_vld),
    .rx_idx   (rx_idx),
    .rx_dat   (rx_dat),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  assign tick = init_done && (samp_cnt == PW'(SAMPLE_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_STARTUP;
    else        state <= state_nxt;
  end

  // Each transaction is launched on the edge that enters its state.
  always_comb begin
    state_nxt  = state;
    xfer_start = 1'b0;
    req        = '0;
    case (state)
      ST_STARTUP: begin
        if (start_cnt == SW'(STARTUP_CYC - 1)) begin
          state_nxt  = ST_CFG_FMT;
          xfer_start = 1'b1;
          req.nbytes = 2'd2;
          req.tx_dat = {spi_cmd(CMD_WRITE_SB, REG_DATA_FORMAT), DATA_FORMAT_VAL, 8'h00};
        end
      end
      ST_CFG_FMT: begin
        if (xfer_done) begin
          state_nxt  = ST_CFG_PWR;
          xfer_start = 1'b1;
          req.nbytes = 2'd2;
          req.tx_dat = {spi_cmd(CMD_WRITE_SB, REG_POWER_CTL), POWER_CTL_VAL, 8'h00};
        end
      end
      ST_CFG_PWR: if (spi_cs_n) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tick && !xfer_busy) begin
          state_nxt  = ST_READ_X;
          xfer_start = 1'b1;
          req.nbytes = 2'd3;
          req.tx_dat = {spi_cmd(CMD_READ_MB, REG_DATAX0), 16'h0000};
        end
      end
      ST_READ_X: if (rx_vld && rx_idx == 2'd2) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_WAIT;
      default:   state_nxt = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt     <= '0;
      samp_cnt      <= '0;
      init_done     <= 1'b0;
      x0_q          <= '0;
      x1_q          <= '0;
      accel_x       <= '0;
      accel_x_valid <= 1'b0;
    end else begin
      if (state == ST_STARTUP) start_cnt <= start_cnt + 1'b1;
      if (state == ST_CFG_PWR && state_nxt == ST_WAIT) init_done <= 1'b1;
      // Sample phase is anchored to the cycle init_done rises.
      if (!init_done || tick) samp_cnt <= '0;
      else                    samp_cnt <= samp_cnt + 1'b1;
      if (state == ST_READ_X && rx_vld) begin
        if (rx_idx == 2'd1) x0_q <= rx_dat;
        if (rx_idx == 2'd2) x1_q <= rx_dat;
      end
      accel_x_valid <= (state == ST_UPDATE);
      if (state == ST_UPDATE) accel_x <= {x1_q, x0_q};
    end
  end

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: behavioural ADXL345 slave, pin timing monitor and per-scenario sample checks.
module tb_accel_spi_reader;

  localparam int HALF    = 2;
  localparam int STARTUP = 100;
  localparam int SAMPLE  = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        spi_cs_n, spi_sclk, spi_mosi;
  logic        spi_miso = 1'b0;
  logic        init_done;
  logic [15:0] accel_x;
  logic        accel_x_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_valid_cyc = -1;

  accel_spi_reader #(
    .CLK_HZ(8_000_000), .SPI_HZ(2_000_000), .STARTUP_CYC(STARTUP), .SAMPLE_CYC(SAMPLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .init_done(init_done), .accel_x(accel_x), .accel_x_valid(accel_x_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADXL345 slave model: shifts MOSI on SCLK rise, drives {junk, X0, X1} on SCLK fall.
  typedef struct { int bits; logic [23:0] dat; } txn_t;
  txn_t        txq[$];
  logic [7:0]  m_x0 = 8'h00, m_x1 = 8'h00;
  logic [23:0] m_mosi = '0;
  logic [23:0] m_resp;
  int          m_bits = 0;
  txn_t        m_t;

  always @(negedge spi_cs_n) begin m_bits = 0; m_mosi = '0; end
  always @(posedge spi_sclk) if (spi_cs_n === 1'b0) begin
    m_mosi = {m_mosi[22:0], spi_mosi};
    m_bits++;
  end
  always @(negedge spi_sclk) if (spi_cs_n === 1'b0) begin
    m_resp = {8'h00, m_x0, m_x1};
    if (m_bits < 24) spi_miso = m_resp[23 - m_bits];
  end
  always @(posedge spi_cs_n) begin
    m_t.bits = m_bits;
    m_t.dat  = m_mosi;
    txq.push_back(m_t);
  end

  // Pin timing monitor, sampled mid-cycle.
  logic p_cs = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0;
  int   t_csf = 0, t_csr = 0, t_edge = 0, t_rise = 0;
  bit   in_setup = 1'b0, have_gap = 1'b0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      p_cs = 1'b1; p_sclk = 1'b1; p_mosi = 1'b0; in_setup = 1'b0; have_gap = 1'b0;
    end else begin
      if (p_cs && !spi_cs_n) begin
        if (have_gap) begin
          checks++;
          if (cyc - t_csr < 2 * HALF) begin
            errors++; $display("FAIL cs_gap: got %0d cycles, need >= %0d", cyc - t_csr, 2 * HALF);
          end
        end
        t_csf = cyc; in_setup = 1'b1;
      end
      if (!spi_cs_n && p_sclk && !spi_sclk) begin
        checks++;
        if (in_setup) begin
          if (cyc - t_csf < HALF) begin
            errors++; $display("FAIL cs_setup: got %0d cycles, need >= %0d", cyc - t_csf, HALF);
          end
          in_setup = 1'b0;
        end else if (cyc - t_edge != HALF) begin
          errors++; $display("FAIL sclk_high: got %0d cycles, need %0d", cyc - t_edge, HALF);
        end
        t_edge = cyc;
      end
      if (!spi_cs_n && !p_sclk && spi_sclk) begin
        checks += 2;
        if (cyc - t_edge != HALF) begin
          errors++; $display("FAIL sclk_low: got %0d cycles, need %0d", cyc - t_edge, HALF);
        end
        if (spi_mosi !== p_mosi) begin
          errors++; $display("FAIL mosi_stable: changed %b->%b at SCLK rise", p_mosi, spi_mosi);
        end
        t_edge = cyc; t_rise = cyc;
      end
      if (!p_cs && spi_cs_n) begin
        checks++;
        if (cyc - t_rise < HALF || spi_sclk !== 1'b1) begin
          errors++; $display("FAIL cs_hold: got %0d cycles sclk=%b, need >= %0d sclk=1", cyc - t_rise, spi_sclk, HALF);
        end
        t_csr = cyc; have_gap = 1'b1;
      end
      p_cs = spi_cs_n; p_sclk = spi_sclk; p_mosi = spi_mosi;
    end
  end

  task automatic count_to_cs_fall(output int n, output bit sclk_moved);
    n = 0; sclk_moved = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (spi_sclk !== 1'b1) sclk_moved = 1'b1;
      if (spi_cs_n === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    int n; bit moved;
    #1 rst_n = 1'b0;
    #1;
    checks += 6;
    if (spi_cs_n !== 1'b1)      begin errors++; $display("FAIL rst_cs_n: got %b, want 1", spi_cs_n); end
    if (spi_sclk !== 1'b1)      begin errors++; $display("FAIL rst_sclk: got %b, want 1", spi_sclk); end
    if (spi_mosi !== 1'b0)      begin errors++; $display("FAIL rst_mosi: got %b, want 0", spi_mosi); end
    if (init_done !== 1'b0)     begin errors++; $display("FAIL rst_init_done: got %b, want 0", init_done); end
    if (accel_x !== 16'h0000)   begin errors++; $display("FAIL rst_accel_x: got %h, want 0000", accel_x); end
    if (accel_x_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, want 0", accel_x_valid); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    txq.delete();
    count_to_cs_fall(n, moved);
    checks += 2;
    if (n < STARTUP - 1 || n > STARTUP + 1) begin
      errors++; $display("FAIL startup_cs_fall: got cycle %0d, want %0d +/-1", n, STARTUP);
    end
    if (moved) begin errors++; $display("FAIL startup_sclk_idle: sclk left 1 before first CS fall"); end
  endtask

  task automatic test_init();
    bit early = 1'b0, ok = 1'b0;
    for (int i = 0; i < 1000 && txq.size() < 2; i++) begin
      @(negedge clk);
      if (txq.size() < 2 && init_done === 1'b1) early = 1'b1;
    end
    checks++;
    if (txq.size() < 2) begin
      errors++; $display("FAIL init_txns: got %0d transactions, want 2", txq.size()); return;
    end
    checks += 5;
    if (early) begin errors++; $display("FAIL init_done_early: rose before 2nd CS rise"); end
    if (txq[0].bits != 16 || txq[0].dat !== 24'h003108) begin
      errors++; $display("FAIL cfg_fmt: got %0d bits %h, want 16 bits 3108", txq[0].bits, txq[0].dat[15:0]);
    end
    if (txq[1].bits != 16 || txq[1].dat !== 24'h002D08) begin
      errors++; $display("FAIL cfg_pwr: got %0d bits %h, want 16 bits 2d08", txq[1].bits, txq[1].dat[15:0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin errors++; $display("FAIL init_done_rise: got %b, want 1 after 2nd CS rise", init_done); end
    repeat (20) @(negedge clk);
    if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_hold: got %b, want 1", init_done); end
    txq.delete();
  endtask

  task automatic test_read(input logic [7:0] x0, input logic [7:0] x1);
    bit ok = 1'b0; int exp, got, vcyc; logic [15:0] held;
    m_x0 = x0; m_x1 = x1;
    txq.delete();
    exp = int'(x1) * 256 + int'(x0);
    if (exp >= 32768) exp -= 65536;
    for (int i = 0; i < SAMPLE + 600; i++) begin
      @(negedge clk);
      if (accel_x_valid === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL read_timeout: no accel_x_valid for X0=%h X1=%h", x0, x1); return; end
    vcyc = cyc;
    got = int'($signed(accel_x));
    checks += 3;
    if (got != exp) begin errors++; $display("FAIL accel_x: got %0d (%h), want %0d", got, accel_x, exp); end
    if (vcyc - t_rise != HALF + 2) begin
      errors++; $display("FAIL valid_latency: got %0d cycles, want %0d", vcyc - t_rise, HALF + 2);
    end
    if (txq.size() != 1 || txq[0].bits != 24 || txq[0].dat !== 24'hF20000) begin
      errors++; $display("FAIL read_mosi: got %0d txns %0d bits %h, want 1 txn 24 bits f20000",
                         txq.size(), (txq.size() > 0) ? txq[0].bits : 0, (txq.size() > 0) ? txq[0].dat : 24'h0);
    end
    if (last_valid_cyc >= 0) begin
      checks++;
      if (vcyc - last_valid_cyc != SAMPLE) begin
        errors++; $display("FAIL sample_period: got %0d cycles, want %0d", vcyc - last_valid_cyc, SAMPLE);
      end
    end
    last_valid_cyc = vcyc;
    held = accel_x;
    @(negedge clk);
    checks += 2;
    if (accel_x_valid !== 1'b0) begin errors++; $display("FAIL valid_width: got %b on 2nd cycle, want 0", accel_x_valid); end
    if (accel_x !== held) begin errors++; $display("FAIL accel_x_hold: got %h, want %h", accel_x, held); end
  endtask

  task automatic test_random_reads(input int n);
    for (int i = 0; i < n; i++) test_read(8'($urandom_range(255)), 8'($urandom_range(255)));
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0; int n; bit moved;
    m_x0 = 8'($urandom_range(255)); m_x1 = 8'($urandom_range(255));
    for (int i = 0; i < SAMPLE + 100; i++) begin
      @(negedge clk);
      if (spi_cs_n === 1'b0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_cs_timeout: read never started"); return; end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_bits >= 10) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_rise_timeout: got %0d SCLK rises, want 10", m_bits); return; end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (spi_cs_n !== 1'b1)      begin errors++; $display("FAIL mid_rst_cs_n: got %b, want 1", spi_cs_n); end
    if (spi_sclk !== 1'b1)      begin errors++; $display("FAIL mid_rst_sclk: got %b, want 1", spi_sclk); end
    if (accel_x !== 16'h0000)   begin errors++; $display("FAIL mid_rst_accel_x: got %h, want 0000", accel_x); end
    if (init_done !== 1'b0)     begin errors++; $display("FAIL mid_rst_init_done: got %b, want 0", init_done); end
    if (accel_x_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, want 0", accel_x_valid); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    txq.delete();
    last_valid_cyc = -1;
    count_to_cs_fall(n, moved);
    checks += 2;
    if (n < STARTUP - 1 || n > STARTUP + 1) begin
      errors++; $display("FAIL restart_cs_fall: got cycle %0d, want %0d +/-1", n, STARTUP);
    end
    if (moved) begin errors++; $display("FAIL restart_sclk_idle: sclk left 1 before first CS fall"); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read(8'h34, 8'h12);
    test_read(8'h00, 8'hFF);
    test_read(8'h05, 8'h00);
    test_random_reads(4);
    test_reset_mid();
    test_init();
    test_random_reads(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
